// File: rtl/scircuit_modsel_seq_if.sv
// Operand/result handshake bundle for scircuit_modsel_seq.
// The producer/consumer side is master; the functional unit is slave.
interface scircuit_modsel_seq_if #(
  parameter int DATAWIDTH = 64
);
  logic                        in_valid;
  logic                        in_ready;
  logic signed [DATAWIDTH-1:0] a;
  logic signed [DATAWIDTH-1:0] b;
  logic signed [DATAWIDTH-1:0] c;
  logic signed [DATAWIDTH-1:0] thr;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [DATAWIDTH-1:0] z;
  logic                        cond;
  logic signed [DATAWIDTH-1:0] rem_out;

  modport master (
    output in_valid, a, b, c, thr, out_ready,
    input  in_ready, out_valid, z, cond, rem_out
  );

  modport slave (
    input  in_valid, a, b, c, thr, out_ready,
    output in_ready, out_valid, z, cond, rem_out
  );
endinterface

// File: rtl/scircuit_modsel_seq.sv
// Multi-cycle signed modulo (restoring shift-subtract) followed by a compare
// against thr and a registered select z = cond ? c : a, with valid/ready I/O.
module scircuit_modsel_seq #(
  parameter int DATAWIDTH = 64,
  parameter int CMP_MODE  = 0
) (
  input logic                  clk,
  input logic                  rst,
  scircuit_modsel_seq_if.slave bus
);
  localparam int W  = DATAWIDTH;
  localparam int IW = $clog2(W + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH, S_DONE} state_t;

  state_t r_state;
  state_t w_state_next;
  logic   w_accept;
  logic   w_step;
  logic   w_finish;

  logic signed [W-1:0] r_a;
  logic signed [W-1:0] r_c;
  logic signed [W-1:0] r_thr;
  logic                r_b_zero;
  logic [W-1:0]        r_quot;
  logic [W-1:0]        r_dvsr;
  logic [W:0]          r_rem;
  logic [IW-1:0]       r_iter;
  logic signed [W-1:0] r_z;
  logic                r_cond;
  logic signed [W-1:0] r_rem_out;

  logic [W-1:0]        w_abs_a;
  logic [W-1:0]        w_abs_b;
  logic [W:0]          w_rem_sh;
  logic                w_ge;
  logic [W:0]          w_rem_step;
  logic [W-1:0]        w_quot_step;
  logic [W-1:0]        w_mag;
  logic [W-1:0]        w_neg_mag;
  logic signed [W-1:0] w_g;
  logic                w_cond;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_accept     = 1'b1;
          w_state_next = S_CALC;
        end
      end
      S_CALC: begin
        w_step = 1'b1;
        if (r_iter == IW'(W - 1)) w_state_next = S_FINISH;
      end
      S_FINISH: begin
        w_finish     = 1'b1;
        w_state_next = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Magnitudes are unsigned W bits, so |-2^(W-1)| = 2^(W-1) fits exactly.
  assign w_abs_a = bus.a[W-1] ? (~bus.a + W'(1)) : bus.a;
  assign w_abs_b = bus.b[W-1] ? (~bus.b + W'(1)) : bus.b;

  assign w_rem_sh    = {r_rem[W-1:0], r_quot[W-1]};
  assign w_ge        = (w_rem_sh >= {1'b0, r_dvsr});
  assign w_rem_step  = w_ge ? (w_rem_sh - {1'b0, r_dvsr}) : w_rem_sh;
  assign w_quot_step = {r_quot[W-2:0], w_ge};

  // Remainder takes the dividend's sign; a zero divisor passes a through.
  assign w_mag     = r_rem[W-1:0];
  assign w_neg_mag = ~w_mag + W'(1);
  assign w_g       = r_b_zero ? r_a : (r_a[W-1] ? $signed(w_neg_mag) : $signed(w_mag));

  always_comb begin
    if (CMP_MODE == 1)      w_cond = (w_g < r_thr);
    else if (CMP_MODE == 2) w_cond = (w_g > r_thr);
    else                    w_cond = (w_g == r_thr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_c       <= '0;
      r_thr     <= '0;
      r_b_zero  <= 1'b0;
      r_quot    <= '0;
      r_dvsr    <= '0;
      r_rem     <= '0;
      r_iter    <= '0;
      r_z       <= '0;
      r_cond    <= 1'b0;
      r_rem_out <= '0;
    end else begin
      if (w_accept) begin
        r_a      <= bus.a;
        r_c      <= bus.c;
        r_thr    <= bus.thr;
        r_b_zero <= (bus.b == '0);
        r_quot   <= w_abs_a;
        r_dvsr   <= w_abs_b;
        r_rem    <= '0;
        r_iter   <= '0;
      end
      if (w_step) begin
        r_rem  <= w_rem_step;
        r_quot <= w_quot_step;
        r_iter <= r_iter + IW'(1);
      end
      if (w_finish) begin
        r_z       <= w_cond ? r_c : r_a;
        r_cond    <= w_cond;
        r_rem_out <= w_g;
      end
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.z         = r_z;
  assign bus.cond      = r_cond;
  assign bus.rem_out   = r_rem_out;
endmodule

// File: tb/tb_scircuit_modsel_seq.sv
// Bench: three 16-bit units (EQ/LT/GT) driven in lockstep against a % model
// with a fixed-latency timing model, plus one 64-bit unit with literal checks.
module tb_scircuit_modsel_seq;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic t_in_valid, t_out_ready;
  logic signed [W-1:0] t_a, t_b, t_c, t_thr;

  logic                o_in_ready  [3];
  logic                o_out_valid [3];
  logic                o_cond      [3];
  logic signed [W-1:0] o_z         [3];
  logic signed [W-1:0] o_rem       [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    scircuit_modsel_seq_if #(.DATAWIDTH(W)) bus ();
    assign bus.in_valid  = t_in_valid;
    assign bus.a         = t_a;
    assign bus.b         = t_b;
    assign bus.c         = t_c;
    assign bus.thr       = t_thr;
    assign bus.out_ready = t_out_ready;
    assign o_in_ready[gi]  = bus.in_ready;
    assign o_out_valid[gi] = bus.out_valid;
    assign o_cond[gi]      = bus.cond;
    assign o_z[gi]         = bus.z;
    assign o_rem[gi]       = bus.rem_out;
    scircuit_modsel_seq #(.DATAWIDTH(W), .CMP_MODE(gi)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  logic t64_in_valid, t64_out_ready;
  logic signed [63:0] t64_a, t64_b, t64_c, t64_thr;
  scircuit_modsel_seq_if #(.DATAWIDTH(64)) b64 ();
  assign b64.in_valid  = t64_in_valid;
  assign b64.a         = t64_a;
  assign b64.b         = t64_b;
  assign b64.c         = t64_c;
  assign b64.thr       = t64_thr;
  assign b64.out_ready = t64_out_ready;
  scircuit_modsel_seq #(.DATAWIDTH(64), .CMP_MODE(0)) u_dut64 (
    .clk (clk),
    .rst (rst),
    .bus (b64)
  );

  int tests = 0;
  int fails = 0;

  // Model: phase 0 idle, 1 computing, 2 result presented.
  int m_phase, m_cnt;
  int p_z[3], p_cond[3], p_rem;
  int e_z[3], e_cond[3], e_rem;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic compute(input int a, input int b, input int c, input int thr);
    int g;
    g = (b == 0) ? a : a % b;
    p_rem = g;
    p_cond[0] = (g == thr) ? 1 : 0;
    p_cond[1] = (g < thr) ? 1 : 0;
    p_cond[2] = (g > thr) ? 1 : 0;
    for (int i = 0; i < 3; i++) p_z[i] = p_cond[i] ? c : a;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_phase = 0;
      e_rem = 0;
      for (int i = 0; i < 3; i++) begin e_z[i] = 0; e_cond[i] = 0; end
    end else begin
      case (m_phase)
        0: if (t_in_valid) begin
             compute(int'(t_a), int'(t_b), int'(t_c), int'(t_thr));
             m_cnt = 0;
             m_phase = 1;
           end
        1: begin
             m_cnt++;
             if (m_cnt == W + 1) begin
               m_phase = 2;
               e_rem = p_rem;
               for (int i = 0; i < 3; i++) begin e_z[i] = p_z[i]; e_cond[i] = p_cond[i]; end
             end
           end
        default: if (t_out_ready) m_phase = 0;
      endcase
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d.in_ready", i), longint'(o_in_ready[i]), (m_phase == 0) ? 1 : 0);
      check($sformatf("u%0d.out_valid", i), longint'(o_out_valid[i]), (m_phase == 2) ? 1 : 0);
      check($sformatf("u%0d.z", i), longint'(o_z[i]), e_z[i]);
      check($sformatf("u%0d.cond", i), longint'(o_cond[i]), e_cond[i]);
      check($sformatf("u%0d.rem_out", i), longint'(o_rem[i]), e_rem);
    end
  endtask

  task automatic run16(input int a, input int b, input int c, input int thr, input bit release_out);
    int lat;
    t_a = W'(a); t_b = W'(b); t_c = W'(c); t_thr = W'(thr);
    t_in_valid = 1'b1;
    t_out_ready = 1'b0;
    tick();
    t_in_valid = 1'b0;
    lat = 0;
    while (!o_out_valid[0] && lat < 40) begin
      tick();
      lat++;
    end
    $display("[TB] txn a=%0d b=%0d c=%0d thr=%0d rem=%0d z=%0d/%0d/%0d lat=%0d",
             a, b, c, thr, o_rem[0], o_z[0], o_z[1], o_z[2], lat);
    check("latency16", lat, W + 1);
    if (release_out) begin
      t_out_ready = 1'b1;
      tick();
      t_out_ready = 1'b0;
    end
  endtask

  task automatic pin(input int i, input int z, input int cond, input int rem);
    check($sformatf("pin_u%0d.z", i), longint'(o_z[i]), z);
    check($sformatf("pin_u%0d.cond", i), longint'(o_cond[i]), cond);
    check($sformatf("pin_u%0d.rem", i), longint'(o_rem[i]), rem);
  endtask

  function automatic logic signed [W-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return W'(1);
      2: return -W'(1);
      3: return W'(16'h8000);
      4: return W'(16'h7fff);
      5: return W'(int'($urandom_range(0, 20)) - 10);
      default: return W'($urandom);
    endcase
  endfunction

  task automatic run64(input longint a, input longint b, input longint c, input longint thr,
                       input longint exp_rem, input longint exp_cond, input longint exp_z);
    int lat;
    t64_a = a; t64_b = b; t64_c = c; t64_thr = thr;
    t64_in_valid = 1'b1;
    tick();
    t64_in_valid = 1'b0;
    lat = 0;
    while (!b64.out_valid && lat < 100) begin
      tick();
      lat++;
    end
    $display("[TB] w64 a=%0d b=%0d rem=%0d cond=%0d z=%0d lat=%0d",
             a, b, b64.rem_out, b64.cond, b64.z, lat);
    check("latency64", lat, 65);
    check("w64.rem", b64.rem_out, exp_rem);
    check("w64.cond", longint'(b64.cond), exp_cond);
    check("w64.z", b64.z, exp_z);
    t64_out_ready = 1'b1;
    tick();
    t64_out_ready = 1'b0;
    check("w64.in_ready_after", longint'(b64.in_ready), 1);
  endtask

  initial begin
    rst = 1'b1;
    t_in_valid = 1'b0; t_out_ready = 1'b0;
    t_a = '0; t_b = '0; t_c = '0; t_thr = '0;
    t64_in_valid = 1'b0; t64_out_ready = 1'b0;
    t64_a = '0; t64_b = '0; t64_c = '0; t64_thr = '0;
    m_phase = 0; m_cnt = 0;
    tick();
    tick();
    rst = 1'b0;
    check("w64.reset_in_ready", longint'(b64.in_ready), 1);
    check("w64.reset_out_valid", longint'(b64.out_valid), 0);
    check("w64.reset_z", b64.z, 0);

    run64(20, 5, 7, 0, 0, 1, 7);
    run64(22, 5, 7, 0, 2, 0, 22);

    run16(17, 5, 11, 3, 1'b1);
    // These pins are checked after release, when values must still hold.
    pin(0, 17, 0, 2); pin(1, 11, 1, 2); pin(2, 17, 0, 2);
    run16(-7, 3, 1, -1, 1'b1);
    pin(0, 1, 1, -1); pin(1, -7, 0, -1);
    run16(7, -3, 5, 0, 1'b1);
    pin(0, 7, 0, 1);
    run16(-32768, -1, 3, 0, 1'b1);
    pin(0, 3, 1, 0);
    run16(-32768, 7, 3, 0, 1'b1);
    pin(0, -32768, 0, -1);
    run16(-45, 0, 9, -45, 1'b1);
    pin(0, 9, 1, -45); pin(1, -45, 0, -45); pin(2, -45, 0, -45);

    // Back-pressure: result held, new operands offered and ignored.
    run16(20, 5, 7, 0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      t_in_valid = k[0];
      t_a = rnd_op(); t_b = rnd_op(); t_c = rnd_op(); t_thr = rnd_op();
      tick();
      check("bp.in_ready", longint'(o_in_ready[0]), 0);
      pin(0, 7, 1, 0);
    end
    t_in_valid = 1'b0;
    t_out_ready = 1'b1;
    tick();
    t_out_ready = 1'b0;
    check("bp.release_in_ready", longint'(o_in_ready[0]), 1);

    // Reset in the middle of a calculation.
    t_a = 16'sd22; t_b = 16'sd5; t_c = 16'sd7; t_thr = '0;
    t_in_valid = 1'b1;
    tick();
    t_in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst.in_ready", longint'(o_in_ready[0]), 1);
    check("rst.out_valid", longint'(o_out_valid[0]), 0);
    check("rst.z", longint'(o_z[0]), 0);
    repeat (25) tick();
    run16(22, 5, 7, 0, 1'b1);
    pin(0, 22, 0, 2);

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 2500; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      t_in_valid = $urandom_range(0, 1) == 1;
      t_a = rnd_op(); t_b = rnd_op(); t_c = rnd_op(); t_thr = rnd_op();
      t_out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0;
    t_in_valid = 1'b0;
    t_out_ready = 1'b1;
    repeat (40) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
